// File: rtl/top_level_pkg.sv
// Shared types and width constants for the sequential restoring divider.
package top_level_pkg;

  localparam int DIVISOR_W  = 8;
  localparam int DIVIDEND_W = 16;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/top_level_datapath.sv
// Divider datapath: operand registers, 9-bit restoring step, iteration counter
// and the registered result outputs.
module div_datapath
  import top_level_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic                  write_i,
  input  logic                  exc_i,
  input  logic [DIVISOR_W-1:0]  a_i,
  input  logic [DIVIDEND_W-1:0] b_i,
  output logic                  exc_o,
  output logic                  cnt_zero_o,
  output logic [DIVISOR_W-1:0]  q_o,
  output logic [DIVISOR_W-1:0]  r_o,
  output logic                  done_o
);

  logic [DIVISOR_W-1:0] dvs_q;
  logic [DIVISOR_W:0]   rem_q, rem_d;
  logic [DIVISOR_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIVISOR_W:0]   shift_rem_s;
  logic [DIVISOR_W:0]   diff_s;
  logic                 ge_s;

  // Overflow when the high dividend byte already reaches the divisor.
  assign exc_o      = (a_i == 8'd0) || (b_i[15:8] >= a_i);
  // High on the step that takes the counter from 1 to 0.
  assign cnt_zero_o = (cnt_q == 4'd1);

  // One restoring step: partial remainder never exceeds 8 bits before the shift.
  always_comb begin
    shift_rem_s = {rem_q[7:0], quo_q[7]};
    diff_s      = shift_rem_s - {1'b0, dvs_q};
    ge_s        = (shift_rem_s >= {1'b0, dvs_q});
    rem_d       = ge_s ? diff_s : shift_rem_s;
    quo_d       = {quo_q[6:0], ge_s};
    cnt_d       = cnt_q - 4'd1;
  end

  // Working registers: load operands or advance one iteration.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dvs_q <= 8'd0;
      rem_q <= 9'd0;
      quo_q <= 8'd0;
      cnt_q <= 4'd0;
    end else if (load_i) begin
      dvs_q <= a_i;
      rem_q <= {1'b0, b_i[15:8]};
      quo_q <= b_i[7:0];
      cnt_q <= 4'd8;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  // Result registers stay zero until the single final write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o    <= 8'd0;
      r_o    <= 8'd0;
      done_o <= 1'b0;
    end else if (write_i) begin
      q_o    <= exc_i ? 8'd0 : quo_d;
      r_o    <= exc_i ? b_i[7:0] : rem_d[7:0];
      done_o <= 1'b1;
    end else begin
      done_o <= done_o;
    end
  end

endmodule

// File: rtl/top_level.sv
// Sequential unsigned restoring divider (Q = B / A, R = B mod A); one division
// per release of the active-low clear.
module top_level
  import top_level_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic [7:0]  A,
  input  logic [15:0] B,
  output logic [7:0]  Q,
  output logic [7:0]  R,
  output logic        Done
);

  state_e state_q, state_d;
  logic   load_s, step_s, write_s, exc_s;
  logic   exc_det_s, cnt_zero_s;

  // Controller state register.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath controls; DONE is absorbing until clear.
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    step_s  = 1'b0;
    write_s = 1'b0;
    exc_s   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        load_s = 1'b1;
        if (exc_det_s) begin
          write_s = 1'b1;
          exc_s   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_DIV: begin
        step_s = 1'b1;
        if (cnt_zero_s) begin
          write_s = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_LOAD;
    endcase
  end

  div_datapath u_datapath (
    .clk_i      (clk),
    .rst_ni     (clear),
    .load_i     (load_s),
    .step_i     (step_s),
    .write_i    (write_s),
    .exc_i      (exc_s),
    .a_i        (A),
    .b_i        (B),
    .exc_o      (exc_det_s),
    .cnt_zero_o (cnt_zero_s),
    .q_o        (Q),
    .r_o        (R),
    .done_o     (Done)
  );

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for the restoring divider: directed cases plus random
// operands compared against plain integer division.
module tb_top_level;

  logic        clk;
  logic        clear;
  logic [7:0]  A;
  logic [15:0] B;
  logic [7:0]  Q;
  logic [7:0]  R;
  logic        Done;

  int n_cmp  = 0;
  int n_fail = 0;

  top_level dut (
    .clk   (clk),
    .clear (clear),
    .A     (A),
    .B     (B),
    .Q     (Q),
    .R     (R),
    .Done  (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_Q"}, {8'd0, Q}, 16'd0);
    check({tag, "_R"}, {8'd0, R}, 16'd0);
    check({tag, "_Done"}, {15'd0, Done}, 16'd0);
  endtask

  // Runs one division from reset release; extra = cycles to watch after Done.
  task automatic run_div(input logic [7:0] a, input logic [15:0] b,
                         input int extra, input bit mutate, input bit end_abort);
    int ia, ib, lat;
    logic [7:0] eq, er;
    ia = a;
    ib = b;
    if (ia == 0 || (ib / ia) > 255) begin
      lat = 1;
      eq  = 8'd0;
      er  = b[7:0];
    end else begin
      lat = 9;
      eq  = 8'(ib / ia);
      er  = 8'(ib % ia);
    end
    clear = 1'b0;
    A = a;
    B = b;
    @(negedge clk);
    clear = 1'b1;
    for (int k = 1; k <= lat + extra; k++) begin
      @(posedge clk);
      #1;
      if (k < lat) begin
        check("busy", {7'd0, Done, Q}, 16'd0);
        check("busy_R", {8'd0, R}, 16'd0);
      end else begin
        check("res_Q", {8'd0, Q}, {8'd0, eq});
        check("res_R", {8'd0, R}, {8'd0, er});
        check("res_Done", {15'd0, Done}, 16'd1);
      end
      if (mutate && k == 1) begin
        A = 8'($urandom);
        B = 16'($urandom);
      end
    end
    if (end_abort) begin
      clear = 1'b0;
      #1;
      check_zero("abort_done");
    end
  endtask

  initial begin
    logic [7:0]  ra;
    logic [15:0] rb;
    clear = 1'b0;
    A = 8'd0;
    B = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");

    run_div(8'd3, 16'd10, 25, 1'b0, 1'b1);
    run_div(8'd0, 16'd11, 3, 1'b0, 1'b1);
    run_div(8'hFF, 16'hFEFF, 2, 1'b0, 1'b0);
    run_div(8'hFF, 16'hFFFF, 2, 1'b0, 1'b1);
    run_div(8'd3, 16'd10, 2, 1'b1, 1'b1);

    // Abort in the 4th DIV cycle, then restart with fresh operands.
    clear = 1'b0;
    A = 8'd3;
    B = 16'd10;
    @(negedge clk);
    clear = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_zero("mid_div");
    clear = 1'b0;
    #1;
    check_zero("abort_div");
    run_div(8'd16, 16'd255, 2, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      if (i % 3 == 0 || ra == 8'd0) begin
        rb = 16'($urandom);
      end else begin
        rb = 16'($urandom_range(0, int'(ra) * 256 - 1));
      end
      run_div(ra, rb, 1, i % 2 == 1, i % 4 == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/top_level.md
TOP_LEVEL -- requirements
Module: top_level

Interface
REQ-001 The design SHALL have no parameters; widths are fixed: divisor 8, dividend 16, quotient 8, remainder 8.
REQ-002 The port list SHALL be, clock and reset first:
- clk  input  1  single clock; all state updates on rising edge.
- clear  input  1  reset, asynchronous, active-low; releasing it (0->1) starts one division.
- A  input  8  unsigned divisor.
- B  input  16  unsigned dividend.
- Q  output  8  unsigned quotient, registered.
- R  output  8  unsigned remainder, registered.
- Done  output  1  high when Q/R hold the final result, registered.

Function
REQ-003 The block SHALL be a sequential unsigned restoring divider computing Q = B / A, R = B mod A.
REQ-004 Controller states SHALL be LOAD, DIV, DONE; reset enters LOAD.
REQ-005 In LOAD, first rising edge after clear goes high: capture A into divisor reg, B[15:8] into 9-bit partial remainder, B[7:0] into quotient shift reg; load iteration counter with 8.
REQ-006 Exception check in LOAD: if A == 0 or B[15:8] >= A (divide-by-zero or quotient exceeds 8 bits), SHALL write Q = 8'h00, R = B[7:0], Done = 1, and go to DONE on that same edge.
REQ-007 Otherwise LOAD SHALL go to DIV.
REQ-008 Each DIV cycle SHALL do one step: shift {remainder, quotient} left 1; if shifted remainder >= divisor, subtract divisor and set quotient LSB to 1, else LSB 0; decrement counter.
REQ-009 After the 8th DIV step (9th rising edge after reset release), SHALL write Q = quotient reg, R = remainder[7:0], set Done = 1, and enter DONE.
REQ-010 DONE SHALL be absorbing: Q, R, Done held until clear is asserted; a new division requires another reset pulse.
REQ-011 A and B SHALL be sampled only in LOAD; changes in DIV or DONE SHALL have no effect.
REQ-012 Q and R SHALL stay 0 and Done SHALL stay 0 until the result is written; no intermediate values appear on Q/R.
REQ-013 Remainder compare/subtract SHALL use 9 bits so the shifted partial remainder never overflows.

Reset
REQ-014 While clear = 0: Q = 8'h00, R = 8'h00, Done = 0, state = LOAD, internal registers cleared, immediately and independent of clk.
REQ-015 Asserting clear mid-DIV or in DONE SHALL abort/discard the operation; the next release restarts from LOAD with fresh A/B.

Structure
REQ-016 A shared package SHALL hold the state enum (LOAD, DIV, DONE) and width constants (divisor 8, dividend 16, counter 4).
REQ-017 The design SHALL be split into controller FSM in top_level plus one sub-module div_datapath (registers, shifter, 9-bit compare/subtract, counter) with load/step/write-result controls and a count-zero status.

Verification
REQ-018 B=10, A=3, release clear -> Done rises after 9th edge; Q=8'h03, R=8'h01; held for 25 further cycles.
REQ-019 B=11, A=0 -> after 1st edge Done=1, Q=8'h00, R=8'h0B.
REQ-020 B=16'hFEFF, A=8'hFF -> after 9 edges Q=8'hFF, R=8'hFE; B=16'hFFFF, A=8'hFF -> after 1 edge Q=8'h00, R=8'hFF, Done=1.
REQ-021 Start B=10, A=3, change A to 5 and B to 100 during DIV -> result still Q=3, R=1.
REQ-022 Assert clear at 4th DIV cycle -> Q=R=0, Done=0 immediately; release with B=255, A=16 -> Q=8'h0F, R=8'h0F after 9 edges.
